// File: rtl/program_memory.sv
`default_nettype none
// ============================================================================
// Module   : program_memory
// Purpose  : Boot-image instruction ROM with a clocked per-word patch overlay;
//            combinational read, asynchronous reset drops all patches.
// Revision : 1.0 - initial release
// ============================================================================
module program_memory #(
    parameter int                ADDR_W       = 5,
    parameter int                DATA_W       = 16,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr_out,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [c_depth-1:0] r_valid;
    logic [DATA_W-1:0]  r_patch [c_depth];
    logic [DATA_W-1:0]  w_boot;

    always_comb begin
        w_boot = DEFAULT_WORD;
        case (int'(address))
            0:  w_boot = DATA_W'(16'h0000);  // load R0
            1:  w_boot = DATA_W'(16'h0006);  // data 6
            2:  w_boot = DATA_W'(16'hA002);  // LSL R0,2
            3:  w_boot = DATA_W'(16'hB001);  // LSR R0,1
            4:  w_boot = DATA_W'(16'h9000);  // SUBi R0
            5:  w_boot = DATA_W'(16'h0004);  // data 4
            6:  w_boot = DATA_W'(16'hC000);  // PUSH R0
            7:  w_boot = DATA_W'(16'hD100);  // POP R1
            8:  w_boot = DATA_W'(16'hE100);  // STR R1,[0]
            9:  w_boot = DATA_W'(16'hF200);  // LD R2,[0]
            10: w_boot = DATA_W'(16'h6101);  // ADDI
            11: w_boot = DATA_W'(16'h5200);  // JMP
            12: w_boot = DATA_W'(16'h8000);  // BRNE
            13: w_boot = DATA_W'(16'h7120);  // CMP R1,R2
            default: w_boot = DEFAULT_WORD;
        endcase
    end

    // Only the valid bits need reset; stale patch words are masked by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            r_patch[wr_addr] <= wr_data;
        end
    end

    assign instr_out = r_valid[address] ? r_patch[address] : w_boot;

endmodule
`default_nettype wire

// File: tb/tb_program_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory
// Purpose  : Randomized scoreboard bench for program_memory against an
//            array model of the visible memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory;

    localparam int c_depth = 32;

    logic        clk;
    logic        rst;
    logic [4:0]  address;
    logic [15:0] instr_out;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clk_run;

    int total;
    int bad;

    // Scoreboard: each entry is the address read and the word expected there.
    typedef struct {
        logic [4:0]  addr;
        logic [15:0] word;
        string       name;
    } exp_t;
    exp_t exp_q[$];
    event ev_sample;

    logic [15:0] boot_img [c_depth];
    logic [15:0] model    [c_depth];

    program_memory #(
        .ADDR_W      (5),
        .DATA_W      (16),
        .DEFAULT_WORD(16'hFFFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .instr_out(instr_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    // Monitor: pops one expectation each time the stimulus presents a read.
    initial begin
        total = 0;
        bad   = 0;
        forever begin
            @(ev_sample);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow addr=%0d got=%h", address, instr_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (address !== e.addr || instr_out !== e.word) begin
                    bad++;
                    $display("FAIL %s addr=%0d got=%h expected=%h", e.name, address, instr_out, e.word);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < c_depth; i++) model[i] = boot_img[i];
    endtask

    task automatic read_check(input logic [4:0] a, input string name);
        exp_t e;
        address = a;
        #1;
        e.addr = a;
        e.word = model[a];
        e.name = name;
        exp_q.push_back(e);
        ->ev_sample;
        #1;
    endtask

    // Drive a write at the negedge, check read-before-edge, commit, check after.
    task automatic patch_write(input logic [4:0] a, input logic [15:0] d, input bit chk);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (chk) read_check(a, "read_before_edge");
        @(posedge clk);
        if (!rst) model[a] = d;
        #1;
        wr_en = 1'b0;
        if (chk) read_check(a, "read_after_edge");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        boot_img[0]  = 16'b0000000000000000;
        boot_img[1]  = 16'b0000000000000110;
        boot_img[2]  = 16'b1010000000000010;
        boot_img[3]  = 16'b1011000000000001;
        boot_img[4]  = 16'b1001000000000000;
        boot_img[5]  = 16'b0000000000000100;
        boot_img[6]  = 16'b1100000000000000;
        boot_img[7]  = 16'b1101000100000000;
        boot_img[8]  = 16'b1110000100000000;
        boot_img[9]  = 16'b1111001000000000;
        boot_img[10] = 16'b0110000100000001;
        boot_img[11] = 16'b0101001000000000;
        boot_img[12] = 16'b1000000000000000;
        boot_img[13] = 16'b0111000100100000;
        for (int i = 14; i < c_depth; i++) boot_img[i] = 16'hFFFF;
        model_reset();

        clk_run = 1'b0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        address = '0;
        #10;
        rst = 1'b0;

        // Boot image sweep with the clock stopped.
        for (int i = 0; i < 14; i++) begin
            address = 5'(i);
            #8;
            read_check(5'(i), "boot_sweep");
        end
        read_check(5'd14, "default_14");
        read_check(5'd31, "default_31");

        clk_run = 1'b1;
        patch_write(5'd3, 16'h1234, 1'b1);
        read_check(5'd3, "patch_3");
        read_check(5'd4, "neighbour_4");
        patch_write(5'd20, 16'h00AA, 1'b1);
        read_check(5'd21, "neighbour_21");
        patch_write(5'd3, 16'h5678, 1'b1);

        // Asynchronous reset between edges drops the patch immediately.
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        read_check(5'd3, "async_reset_3");
        read_check(5'd20, "async_reset_20");
        #1;
        rst = 1'b0;

        // Writes while in reset are ignored.
        rst = 1'b1;
        patch_write(5'd0, 16'hBEEF, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        read_check(5'd0, "write_in_reset_0");

        // Randomized writes, reads and occasional asynchronous resets.
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel < 8) begin
                patch_write(5'($urandom_range(0, 31)), 16'($urandom), sel < 2);
            end else if (sel == 19) begin
                @(negedge clk);
                #1;
                rst = 1'b1;
                model_reset();
                read_check(5'($urandom_range(0, 31)), "rand_reset_read");
                rst = 1'b0;
            end else begin
                read_check(5'($urandom_range(0, 31)), "rand_read");
            end
        end

        // Full sweep to catch any stray patched location.
        for (int i = 0; i < c_depth; i++) read_check(5'(i), "final_sweep");

        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
